// File: rtl/aes_round_key_sequencer.sv
// Buffers a full AES key schedule on load and streams one round key per valid/ready transfer,
// forward for encryption or reverse for decryption. Define AES_EQINV_KEY_EN for equivalent-inverse-cipher keys.
module aes_round_key_sequencer #(
  parameter int NR = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    dec_mode,
  input  logic [(NR+1)*128-1:0]   key_sched_in,
  output logic [127:0]            rk_out,
  output logic [3:0]              rk_round,
  output logic                    rk_valid,
  input  logic                    rk_ready,
  output logic                    rk_last,
  output logic                    busy
);

  localparam logic [0:0] STATE_IDLE   = 1'b0;
  localparam logic [0:0] STATE_STREAM = 1'b1;
  localparam logic [3:0] LAST_ROUND   = 4'(NR);

  logic [0:0]             state_q, state_d;
  logic [(NR+1)*128-1:0]  sched_q, sched_d;
  logic                   dec_q, dec_d;
  logic [127:0]           rk_out_q, rk_out_d;
  logic [3:0]             rk_round_q, rk_round_d;
  logic                   rk_valid_q, rk_valid_d;
  logic                   rk_last_q, rk_last_d;

  logic [127:0] rk_arr [NR+1];
  logic [3:0]   round_step;
  logic [3:0]   end_round;
  logic [3:0]   first_round;
  logic [3:0]   first_end;
  logic [127:0] key_raw;
  logic [127:0] key_step;
  logic [127:0] key_first;
  logic         xfer;

  // Round j sits at the MSB end shifted down by j keys.
  genvar gi;
  generate
    for (gi = 0; gi <= NR; gi++) begin : g_rk_slice
      assign rk_arr[gi] = sched_q[(NR+1)*128-1-gi*128 -: 128];
    end
  endgenerate

`ifdef AES_EQINV_KEY_EN
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] k);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) begin
      r[127-32*i -: 32] = inv_mix_col(k[127-32*i -: 32]);
    end
    return r;
  endfunction
`endif

  assign xfer        = rk_valid_q & rk_ready;
  assign round_step  = dec_q ? (rk_round_q - 4'd1) : (rk_round_q + 4'd1);
  assign end_round   = dec_q ? 4'd0 : LAST_ROUND;
  assign first_round = dec_mode ? LAST_ROUND : 4'd0;
  assign first_end   = dec_mode ? 4'd0 : LAST_ROUND;
  assign key_first   = dec_mode ? key_sched_in[127:0]
                                : key_sched_in[(NR+1)*128-1 -: 128];
  assign key_raw     = rk_arr[round_step];

`ifdef AES_EQINV_KEY_EN
  // Only the middle decryption keys need InvMixColumns; first/last keys of either order pass through.
  assign key_step = (dec_q && (round_step != 4'd0) && (round_step != LAST_ROUND))
                    ? inv_mix(key_raw) : key_raw;
`else
  assign key_step = key_raw;
`endif

  always_comb begin
    state_d    = state_q;
    sched_d    = sched_q;
    dec_d      = dec_q;
    rk_out_d   = rk_out_q;
    rk_round_d = rk_round_q;
    rk_valid_d = rk_valid_q;
    rk_last_d  = rk_last_q;
    case (state_q)
      STATE_IDLE: begin
        if (load) begin
          state_d    = STATE_STREAM;
          sched_d    = key_sched_in;
          dec_d      = dec_mode;
          rk_round_d = first_round;
          rk_out_d   = key_first;
          rk_valid_d = 1'b1;
          rk_last_d  = (first_round == first_end);
        end
      end
      default: begin
        if (xfer) begin
          if (rk_last_q) begin
            state_d    = STATE_IDLE;
            rk_valid_d = 1'b0;
            rk_last_d  = 1'b0;
          end else begin
            rk_round_d = round_step;
            rk_out_d   = key_step;
            rk_last_d  = (round_step == end_round);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= STATE_IDLE;
      sched_q    <= '0;
      dec_q      <= 1'b0;
      rk_out_q   <= '0;
      rk_round_q <= '0;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sched_q    <= sched_d;
      dec_q      <= dec_d;
      rk_out_q   <= rk_out_d;
      rk_round_q <= rk_round_d;
      rk_valid_q <= rk_valid_d;
      rk_last_q  <= rk_last_d;
    end
  end

  assign rk_out   = rk_out_q;
  assign rk_round = rk_round_q;
  assign rk_valid = rk_valid_q;
  assign rk_last  = rk_last_q;
  assign busy     = (state_q != STATE_IDLE);

endmodule

// File: tb/tb_aes_round_key_sequencer.sv
// Scoreboard bench for aes_round_key_sequencer: forward, reverse, stall with ignored load,
// async reset mid-stream and the equivalent-inverse key path (when AES_EQINV_KEY_EN is defined).
module tb_aes_round_key_sequencer;
  localparam int NR = 10;
  localparam int SW = (NR+1)*128;

  logic          clk;
  logic          rst_n;
  logic          load;
  logic          dec_mode;
  logic [SW-1:0] key_sched_in;
  logic [127:0]  rk_out;
  logic [3:0]    rk_round;
  logic          rk_valid;
  logic          rk_ready;
  logic          rk_last;
  logic          busy;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   rnd;
    logic         last;
  } exp_t;

  exp_t         sb_q [$];
  logic [127:0] sk [0:NR];
  int           checks = 0;
  int           errors = 0;
  int           xfer_cnt = 0;

  aes_round_key_sequencer #(.NR(NR)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .dec_mode(dec_mode),
    .key_sched_in(key_sched_in), .rk_out(rk_out), .rk_round(rk_round),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_last(rk_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model_inv_mix(input logic [127:0] k);
    logic [7:0]   m [4];
    logic [7:0]   acc;
    logic [127:0] r;
    m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int c = 0; c < 4; c++)
          acc ^= gmul(k[127-32*col-8*c -: 8], m[(c - row + 4) % 4]);
        r[127-32*col-8*row -: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [SW-1:0] pack_sched();
    logic [SW-1:0] v;
    for (int j = 0; j <= NR; j++) v[SW-1-j*128 -: 128] = sk[j];
    return v;
  endfunction

  function automatic logic [SW-1:0] rand_sched();
    logic [SW-1:0] v;
    for (int j = 0; j < SW/32; j++) v[32*j +: 32] = $urandom;
    return v;
  endfunction

  task automatic push_seq(input logic dec, input logic r1_const);
    exp_t e;
    for (int i = 0; i <= NR; i++) begin
      int r;
      r = dec ? NR - i : i;
      e.key = sk[r];
`ifdef AES_EQINV_KEY_EN
      if (dec && r != 0 && r != NR) e.key = model_inv_mix(sk[r]);
      if (r1_const && r == 1) e.key = {4{32'hdb135345}};
`else
      if (r1_const && r == 1) e.key = {4{32'h8e4da1bc}};
`endif
      e.rnd  = 4'(r);
      e.last = (i == NR);
      sb_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) chk("valid_while_busy", 128'(rk_valid), 128'd1);
      else      chk("valid_while_idle", 128'(rk_valid), 128'd0);
      if (rk_valid && rk_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_xfer", 128'(rk_round), 128'hx);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          $display("xfer round=%0d last=%0d key=%h", rk_round, rk_last, rk_out);
          chk("rk_out", rk_out, e.key);
          chk("rk_round", 128'(rk_round), 128'(e.rnd));
          chk("rk_last", 128'(rk_last), 128'(e.last));
        end
        xfer_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    chk("idle_timeout", 128'(busy), 128'd0);
    chk("sb_empty", 128'(sb_q.size()), 128'd0);
  endtask

  task automatic start(input logic dec, input logic r1_const);
    key_sched_in = pack_sched();
    dec_mode     = dec;
    push_seq(dec, r1_const);
    xfer_cnt     = 0;
    load         = 1'b1;
    tick();
    load         = 1'b0;
  endtask

  task automatic load_fips();
    sk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    sk[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    sk[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    sk[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    sk[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    sk[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    sk[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    sk[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    sk[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    sk[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    sk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; load = 1'b0; dec_mode = 1'b0; rk_ready = 1'b0;
    key_sched_in = '0;
    load_fips();
    tick(); tick();
    chk("rst_rk_out", rk_out, 128'd0);
    chk("rst_rk_round", 128'(rk_round), 128'd0);
    chk("rst_rk_valid", 128'(rk_valid), 128'd0);
    chk("rst_rk_last", 128'(rk_last), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    rst_n = 1'b1;
    tick();

    // forward order; input schedule scrambled after capture
    rk_ready = 1'b1;
    start(1'b0, 1'b0);
    chk("fwd_busy_after_load", 128'(busy), 128'd1);
    key_sched_in = rand_sched();
    wait_idle();
    chk("fwd_xfers", 128'(xfer_cnt), 128'd11);
    chk("fwd_last_clear", 128'(rk_last), 128'd0);

    // reverse order
    start(1'b1, 1'b0);
    wait_idle();
    chk("rev_xfers", 128'(xfer_cnt), 128'd11);

    // stall at round 8 with an ignored load, then load coincident with final transfer
    start(1'b1, 1'b0);
    n = 0;
    while (rk_round != 4'd8 && n < 20) begin tick(); n++; end
    rk_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_key", rk_out, sk[8]);
      chk("stall_round", 128'(rk_round), 128'd8);
      chk("stall_valid", 128'(rk_valid), 128'd1);
      if (i == 1) begin
        load = 1'b1; dec_mode = 1'b0; key_sched_in = rand_sched();
      end
      if (i == 2) load = 1'b0;
    end
    tick();
    rk_ready = 1'b1;
    n = 0;
    while (!rk_last && n < 20) begin tick(); n++; end
    chk("rev_reach_last", 128'(rk_last), 128'd1);
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("final_load_busy", 128'(busy), 128'd0);
    chk("final_load_valid", 128'(rk_valid), 128'd0);
    tick();
    chk("final_load_no_restart", 128'(busy), 128'd0);
    chk("stall_sb_empty", 128'(sb_q.size()), 128'd0);
    chk("stall_xfers", 128'(xfer_cnt), 128'd11);

    // async reset mid-stream
    start(1'b0, 1'b0);
    n = 0;
    while (rk_round != 4'd4 && n < 20) begin tick(); n++; end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rk_out", rk_out, 128'd0);
    chk("arst_rk_round", 128'(rk_round), 128'd0);
    chk("arst_rk_valid", 128'(rk_valid), 128'd0);
    chk("arst_rk_last", 128'(rk_last), 128'd0);
    chk("arst_busy", 128'(busy), 128'd0);
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    start(1'b0, 1'b0);
    chk("restart_round", 128'(rk_round), 128'd0);
    wait_idle();

    // equivalent-inverse key path (raw pass-through when the macro is undefined)
    sk[1] = {4{32'h8e4da1bc}};
    start(1'b1, 1'b1);
    wait_idle();
    chk("eqinv_xfers", 128'(xfer_cnt), 128'd11);
    chk("eqinv_model_sanity", model_inv_mix({4{32'h8e4da1bc}}), {4{32'hdb135345}});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_round_key_sequencer.md
Name: aes_round_key_sequencer

Overview:
- Registered buffer and streamer placed directly downstream of the combinational key expansion block.
- Captures the full 11-round-key schedule (1408 bits) on a load pulse.
- Streams one 128-bit round key per transfer over a valid/ready handshake to the iterative round datapath.
- Order is forward (round 0 to 10) for encryption or reverse (round 10 to 0) for decryption.

Parameters:
- NR, 10, number of AES rounds. The schedule input width is (NR+1)*128. Only 10 is used by AES-128; other values are for reuse only.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  single-cycle request to capture key_sched_in and start streaming.
- dec_mode  input  1  sampled with load. 1 selects reverse order, 0 selects forward order.
- key_sched_in  input  (NR+1)*128  expanded schedule. Round j occupies bits [(NR+1)*128-1-j*128 -: 128], so round 0 is in the MSBs.
- rk_out  output  128  current round key.
- rk_round  output  4  round index of rk_out.
- rk_valid  output  1  rk_out/rk_round hold valid data.
- rk_ready  input  1  consumer accepts the current key.
- rk_last  output  1  high with rk_valid when the current key is the final one in the sequence.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, rst_n low): state=IDLE; all outputs 0 (rk_out=0, rk_round=0, rk_valid=0, rk_last=0, busy=0); schedule register cleared; mode flag cleared.
- FSM states: IDLE, STREAM.
- IDLE:
  - load=1 at edge N: capture key_sched_in and dec_mode into internal registers and go to STREAM.
  - The round counter starts at NR if dec_mode=1, otherwise at 0.
  - At cycle N+1: rk_valid=1, rk_out = first key, busy=1. Load-to-valid latency is 1 cycle.
- STREAM:
  - A transfer occurs on any edge where rk_valid & rk_ready.
  - On a transfer the counter steps by -1 (dec) or +1 (enc), and the next key appears the following cycle.
  - rk_valid stays high between keys.
  - Back-to-back transfers with rk_ready held high deliver one key per cycle: 11 consecutive cycles.
- Stall: while rk_valid=1 and rk_ready=0, rk_out, rk_round and rk_last are held stable. No skipping, no timeout.
- rk_last=1 when the counter is 0 (dec) or NR (enc).
  - A transfer with rk_last=1 returns the FSM to IDLE.
  - rk_valid=0, rk_last=0 and busy=0 from the next cycle.
  - rk_out keeps its last value; it is don't-care.
- load while busy=1 is ignored: no recapture, no restart. The stream completes with the originally captured schedule.
- load coincident with the final transfer is also ignored. The new load is accepted only from IDLE.
- The counter never wraps. Underflow below 0 and overflow above NR are unreachable by construction.
- The captured schedule is independent of later changes on key_sched_in. Changing the key mid-stream has no effect.
- rst_n asserted mid-stream aborts immediately to the reset values. The next load restarts from the first key.
- All outputs are registered. There is no combinational path from load, rk_ready or key_sched_in to any output.

Optional Feature:
- Macro: AES_EQINV_KEY_EN
- Defined:
  - In dec_mode, round keys with index 1..NR-1 are output as InvMixColumns(rk). Each of the 4 columns uses GF(2^8) multiplies by 0e/0b/0d/09, with 11b reduction.
  - Rounds 0 and NR are passed through unchanged. Encryption mode is unaffected.
  - This supports the equivalent inverse cipher.
  - The transform is applied to the registered slice before the rk_out register, so latency is unchanged.
- Undefined: all keys are passed through raw in both modes, and no GF logic is instantiated.

Test Plan:
- Forward order: drive key_sched_in = expansion of key 000102030405060708090a0b0c0d0e0f; dec_mode=0, pulse load, rk_ready=1.
  - Cycle after load: rk_out=000102030405060708090a0b0c0d0e0f, rk_round=0.
  - Next key: d6aa74fdd2af72fadaa678f1d6ab76fe, rk_round=1.
  - 11th key: 13111d7fe3944a17f307a78b4d2b30c5, rk_round=10, rk_last=1.
  - busy=0 one cycle later.
- Reverse order: same schedule with dec_mode=1.
  - First key: 13111d7f..., rk_round=10.
  - Last key: 00010203..., rk_round=0, rk_last=1.
  - Exactly 11 transfers.
- Stall and ignored load: dec_mode=1, rk_ready low for 5 cycles after the 3rd key.
  - rk_out must stay at the rk_round=8 key and rk_valid must stay 1.
  - A load pulse during the stall is ignored and the sequence continues from round 8.
- Reset mid-stream: assert rst_n low asynchronously mid-clock at round 4.
  - All outputs go to 0 immediately.
  - After release, a new load restarts from round 0 (enc).
- AES_EQINV_KEY_EN defined, dec_mode=1, schedule with the round-1 slice = 8e4da1bc repeated in all four columns.
  - rk_round=1 output = db135345 in all four columns.
  - Round 10 and round 0 keys are unchanged.
  - With the macro undefined, the round-1 output = 8e4da1bc in all four columns.
